// File: rtl/alu_frame_pkg.sv
// Shared types and constants for the UART ALU frame engine.
// Contents: opcode enum, FSM state enum, status byte layout, opcode decode helpers.
// Optional feature macro: ALU_SATURATE_EN (enables ADDS/SUBS opcodes).
package alu_frame_pkg;

  typedef enum logic [7:0] {
    OP_ADD  = 8'h00,
    OP_SUB  = 8'h01,
    OP_ADC  = 8'h02,
    OP_CMP  = 8'h03,
    OP_ADDS = 8'h04,
    OP_SUBS = 8'h05
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RX_A    = 3'd1,
    S_RX_B    = 3'd2,
    S_COMPUTE = 3'd3,
    S_TX_RES  = 3'd4,
    S_TX_STAT = 3'd5
  } state_t;

  localparam logic [7:0]  STAT_ERR = 8'h80;
  localparam int unsigned ST_C     = 0;
  localparam int unsigned ST_Z     = 1;
  localparam int unsigned ST_N     = 2;
  localparam int unsigned ST_V     = 3;

  // Opcodes accepted by the engine in this build.
  function automatic logic op_valid(input logic [7:0] op);
`ifdef ALU_SATURATE_EN
    return (op <= 8'h05);
`else
    return (op <= 8'h03);
`endif
  endfunction

  // Opcodes that add the inverted B operand with carry-in 1.
  function automatic logic op_is_sub(input logic [7:0] op);
    return (op == OP_SUB) || (op == OP_CMP) || (op == OP_SUBS);
  endfunction

  // Signed saturating opcodes.
  function automatic logic op_is_sat(input logic [7:0] op);
    return (op == OP_ADDS) || (op == OP_SUBS);
  endfunction

endpackage

// File: rtl/alu_chunk_adder.sv
// CHUNK-wide adder slice with a registered carry between chunks.
// Ports: sys_clk/rst (async active-low), start (first chunk, uses cin),
//        a/b chunk operands, cin, sum/cout for the current chunk,
//        done (current chunk is the last of NC).
module alu_chunk_adder #(
  parameter int unsigned CHUNK = 8,
  parameter int unsigned NC    = 4
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             done
);

  localparam int unsigned CW = $clog2(NC + 1);
  localparam int unsigned SW = CHUNK + 1;

  logic          carry_q;
  logic          run_q;
  logic [CW-1:0] cnt_q;
  logic          active_c;
  logic          c_in_c;

  assign active_c    = start || run_q;
  assign c_in_c      = start ? cin : carry_q;
  assign {cout, sum} = SW'(a) + SW'(b) + SW'(c_in_c);
  assign done        = start ? (NC == 1) : (run_q && (cnt_q == CW'(NC - 1)));

  // Carry and chunk counter for the running operation.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      carry_q <= 1'b0;
      run_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (active_c) carry_q <= cout;
      if (start) begin
        run_q <= (NC > 1);
        cnt_q <= CW'(1);
      end else if (run_q) begin
        if (done) run_q <= 1'b0;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_alu_frame_engine.sv
// Byte-stream ALU: parses {opcode, A, B} frames from UART RX, computes over
// WIDTH bits CHUNK bits per cycle, returns result bytes and a status byte.
// Ports: sys_clk, rst (async active-low), rx_byte/rx_valid, tx_byte/tx_valid/
//        tx_ready, busy, carry_flag, err_timeout, err_overrun.
// Optional feature macro: ALU_SATURATE_EN (signed saturating ADDS/SUBS).
module uart_alu_frame_engine
  import alu_frame_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned CHUNK       = 8,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       carry_flag,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam int unsigned NB  = WIDTH / 8;
  localparam int unsigned NC  = WIDTH / CHUNK;
  localparam int unsigned BCW = $clog2(NB + 1);
  localparam int unsigned TOW = $clog2(TIMEOUT_CYC + 1);

  state_t           state_q, state_d;
  logic [7:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [7:0]       stat_q, stat_d;
  logic [BCW-1:0]   cnt_q, cnt_d;
  logic [TOW-1:0]   idle_q, idle_d;
  logic             start_q, start_d;
  logic [7:0]       tx_byte_d;
  logic             tx_valid_d, carry_d, err_to_d, err_ov_d;

  logic [CHUNK-1:0] add_a_c, add_b_c, add_sum_c;
  logic             add_cin_c, add_cout_c, add_done_c;
  logic             sat_c, ovf_c;
  logic [WIDTH-1:0] res_raw_c, res_c, res_sh_c;
  logic [7:0]       stat_c;
  logic             last_c, tx_xfer_c, timeout_c;

  assign last_c    = (cnt_q == BCW'(NB - 1));
  assign tx_xfer_c = tx_valid && tx_ready;
  assign timeout_c = ((state_q == S_RX_A) || (state_q == S_RX_B)) && !rx_valid &&
                     (idle_q == TOW'(TIMEOUT_CYC - 1));

  // Operand chunks are consumed LSB first; B is inverted for subtraction.
  assign add_a_c   = a_q[CHUNK-1:0];
  assign add_b_c   = op_is_sub(op_q) ? ~b_q[CHUNK-1:0] : b_q[CHUNK-1:0];
  assign add_cin_c = op_is_sub(op_q) || ((op_q == OP_ADC) && carry_flag);

  alu_chunk_adder #(.CHUNK(CHUNK), .NC(NC)) u_adder (
    .sys_clk (sys_clk),
    .rst     (rst),
    .start   (start_q),
    .a       (add_a_c),
    .b       (add_b_c),
    .cin     (add_cin_c),
    .sum     (add_sum_c),
    .cout    (add_cout_c),
    .done    (add_done_c)
  );

  // Result assembly and flags; on the last chunk the operand MSBs are on the adder inputs.
  always_comb begin
`ifdef ALU_SATURATE_EN
    sat_c = op_is_sat(op_q);
`else
    sat_c = 1'b0;
`endif
    ovf_c     = (add_a_c[CHUNK-1] == add_b_c[CHUNK-1]) && (add_sum_c[CHUNK-1] != add_a_c[CHUNK-1]);
    res_raw_c = (res_q >> CHUNK) | (WIDTH'(add_sum_c) << (WIDTH - CHUNK));
    res_c     = res_raw_c;
    if (add_done_c && sat_c && ovf_c) begin
      res_c = add_a_c[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    stat_c       = 8'h00;
    stat_c[ST_V] = ovf_c;
    stat_c[ST_N] = res_c[WIDTH-1];
    stat_c[ST_Z] = (res_c == '0);
    stat_c[ST_C] = add_cout_c;
    res_sh_c     = res_q << 8;
  end

  // State register.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (rx_valid) state_d = op_valid(rx_byte) ? S_RX_A : S_TX_STAT;
      S_RX_A:    if (timeout_c) state_d = S_IDLE;
                 else if (rx_valid && last_c) state_d = S_RX_B;
      S_RX_B:    if (timeout_c) state_d = S_IDLE;
                 else if (rx_valid && last_c) state_d = S_COMPUTE;
      S_COMPUTE: if (add_done_c) state_d = (op_q == OP_CMP) ? S_TX_STAT : S_TX_RES;
      S_TX_RES:  if (tx_xfer_c && last_c) state_d = S_TX_STAT;
      S_TX_STAT: if (tx_xfer_c) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    stat_d     = stat_q;
    cnt_d      = cnt_q;
    idle_d     = '0;
    start_d    = 1'b0;
    tx_byte_d  = tx_byte;
    tx_valid_d = tx_valid;
    carry_d    = carry_flag;
    err_to_d   = 1'b0;
    err_ov_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_valid) begin
          op_d = rx_byte;
          if (!op_valid(rx_byte)) begin
            tx_byte_d  = STAT_ERR;
            tx_valid_d = 1'b1;
          end
        end
      end
      S_RX_A, S_RX_B: begin
        idle_d = idle_q + TOW'(1);
        if (timeout_c) begin
          idle_d   = '0;
          cnt_d    = '0;
          err_to_d = 1'b1;
        end else if (rx_valid) begin
          idle_d = '0;
          if (state_q == S_RX_A) a_d = (a_q << 8) | WIDTH'(rx_byte);
          else                   b_d = (b_q << 8) | WIDTH'(rx_byte);
          cnt_d = last_c ? '0 : cnt_q + BCW'(1);
          if ((state_q == S_RX_B) && last_c) start_d = 1'b1;
        end
      end
      S_COMPUTE: begin
        err_ov_d = rx_valid;
        a_d      = a_q >> CHUNK;
        b_d      = b_q >> CHUNK;
        res_d    = res_c;
        if (add_done_c) begin
          stat_d     = stat_c;
          carry_d    = add_cout_c;
          tx_byte_d  = (op_q == OP_CMP) ? stat_c : res_c[WIDTH-1 -: 8];
          tx_valid_d = 1'b1;
        end
      end
      S_TX_RES: begin
        err_ov_d = rx_valid;
        if (tx_xfer_c) begin
          if (last_c) begin
            tx_byte_d = stat_q;
            cnt_d     = '0;
          end else begin
            res_d     = res_sh_c;
            tx_byte_d = res_sh_c[WIDTH-1 -: 8];
            cnt_d     = cnt_q + BCW'(1);
          end
        end
      end
      S_TX_STAT: begin
        err_ov_d = rx_valid;
        if (tx_xfer_c) begin
          tx_byte_d  = 8'h00;
          tx_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      stat_q      <= '0;
      cnt_q       <= '0;
      idle_q      <= '0;
      start_q     <= 1'b0;
      tx_byte     <= 8'h00;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      carry_flag  <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      stat_q      <= stat_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      start_q     <= start_d;
      tx_byte     <= tx_byte_d;
      tx_valid    <= tx_valid_d;
      busy        <= (state_d != S_IDLE);
      carry_flag  <= carry_d;
      err_timeout <= err_to_d;
      err_overrun <= err_ov_d;
    end
  end

endmodule
